// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared constants and helpers for the pipelined adder
`timescale 1ns/1ps
package pipe_adder_pkg;
   localparam int DEFAULT_WIDTH  = 16;
   localparam int DEFAULT_STAGES = 4;
   localparam int DEFAULT_CW     = DEFAULT_WIDTH / DEFAULT_STAGES;

   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

   // Legal split: 1..width stages that divide the width evenly.
   function automatic bit split_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction
endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - one CW-bit add with registered sum and carry
`timescale 1ns/1ps
module adder_chunk #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          cin,
   output logic [CW-1:0] sum,
   output logic          cout
);
   logic [CW:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
      end else if (en) begin
         sum  <= total[CW-1:0];
         cout <= total[CW];
      end
   end
endmodule

// File: rtl/pipe_n_bit_adder.sv
// rtl/pipe_n_bit_adder.sv - WIDTH-bit add/subtract split into STAGES carry-registered chunks
`timescale 1ns/1ps
module pipe_n_bit_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = chunk_width(WIDTH, STAGES);

   if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
      $error("pipe_n_bit_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
   end

   logic                          adv;
   logic [WIDTH-1:0]              b_eff;
   logic                          cin_eff;
   logic [STAGES-1:0][WIDTH-1:0]  a_q;
   logic [STAGES-1:0][WIDTH-1:0]  b_q;
   logic [STAGES-1:0][WIDTH-1:0]  ssum;
   logic [STAGES-1:0]             carry_q;
   logic [STAGES-1:0]             valid_q;

   // The whole pipe moves as one; any stall at the output freezes every stage.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign b_eff    = b ^ {WIDTH{sub}};
   assign cin_eff  = sub | cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_in, b_in, d_in;
      logic [WIDTH-1:0] a_r, b_r, d_r, s_full;
      logic             c_in, v_in, v_r, c_out;
      logic [CW-1:0]    c_sum;

      if (k == 0) begin : g_head
         assign a_in = a;
         assign b_in = b_eff;
         assign c_in = cin_eff;
         assign d_in = '0;
         assign v_in = in_valid;
      end else begin : g_tail
         assign a_in = a_q[k-1];
         assign b_in = b_q[k-1];
         assign c_in = carry_q[k-1];
         assign d_in = ssum[k-1];
         assign v_in = valid_q[k-1];
      end

      adder_chunk #(.CW(CW)) u_chunk (
         .clk  (clk),
         .rst_n(rst_n),
         .en   (adv),
         .a    (a_in[k*CW +: CW]),
         .b    (b_in[k*CW +: CW]),
         .cin  (c_in),
         .sum  (c_sum),
         .cout (c_out)
      );

      // Full operands ride along so later chunks and the overflow MSBs stay aligned.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            d_r <= '0;
            v_r <= 1'b0;
         end else if (adv) begin
            a_r <= a_in;
            b_r <= b_in;
            d_r <= d_in;
            v_r <= v_in;
         end
      end

      always_comb begin
         s_full = d_r;
         s_full[k*CW +: CW] = c_sum;
      end

      assign a_q[k]     = a_r;
      assign b_q[k]     = b_r;
      assign ssum[k]    = s_full;
      assign carry_q[k] = c_out;
      assign valid_q[k] = v_r;
   end

   assign out_valid = valid_q[STAGES-1];
   assign sum       = ssum[STAGES-1];
   assign cout      = carry_q[STAGES-1];
   assign ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                      (sum[WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
endmodule

// File: tb/tb_pipe_n_bit_adder.sv
// tb/tb_pipe_n_bit_adder.sv - directed and randomized checks of pipe_n_bit_adder
`timescale 1ns/1ps
module tb_pipe_n_bit_adder;
   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a, b, sum;
   logic        cin, sub, cout, ovf;
   int          total = 0;
   int          bad   = 0;
   int          phase = 0;

   pipe_n_bit_adder #(.WIDTH(16), .STAGES(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} from plain integer arithmetic at width w.
   function automatic logic [33:0] ref_model(input int w, input logic [31:0] a_v, input logic [31:0] b_v,
                                             input logic cin_v, input logic sub_v);
      longint m, ua, ub, sa, sb, full, r;
      logic co, ov;
      m  = (longint'(1) << w) - 1;
      ua = longint'({32'd0, a_v}) & m;
      ub = longint'({32'd0, b_v}) & m;
      sa = (ua > (m >> 1)) ? ua - (m + 1) : ua;
      sb = (ub > (m >> 1)) ? ub - (m + 1) : ub;
      if (sub_v) begin
         full = ua - ub;
         co   = (ua >= ub);
         r    = sa - sb;
      end else begin
         full = ua + ub + longint'(cin_v);
         co   = (full > m);
         r    = sa + sb + longint'(cin_v);
      end
      ov = (r > (m >> 1)) || (r < -((m >> 1) + 1));
      return {ov, co, 32'(full & m)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic sv, input logic [15:0] es,
                         input logic ec, input logic eo);
      int n;
      out_ready = 1'b1;
      a = av; b = bv; cin = cv; sub = sv;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, n, 4);
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, cout, ec);
      check({tag, "_ovf"}, ovf, eo);
      tick();
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_wide
      localparam int S = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
      logic        iv, ir, ov, ordy, c, s, co, of, fin;
      logic [31:0] wa, wb, ws;

      pipe_n_bit_adder #(.WIDTH(32), .STAGES(S)) u_dut (
         .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
         .a(wa), .b(wb), .cin(c), .sub(s), .out_valid(ov),
         .out_ready(ordy), .sum(ws), .cout(co), .ovf(of)
      );

      initial begin
         logic [33:0] q[$];
         logic [33:0] e;
         int          got;
         iv = 1'b0; ordy = 1'b0; wa = '0; wb = '0; c = 1'b0; s = 1'b0;
         fin = 1'b0; got = 0;
         wait (phase == g + 1);
         for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc < 300) begin
               iv   = ($urandom_range(0, 3) != 0);
               wa   = $urandom;
               wb   = $urandom;
               c    = 1'($urandom_range(0, 1));
               s    = 1'($urandom_range(0, 1));
               ordy = ($urandom_range(0, 3) != 0);
            end else begin
               iv   = 1'b0;
               ordy = 1'b1;
            end
            #1;
            if (iv && ir) q.push_back(ref_model(32, wa, wb, c, s));
            if (ov && ordy) begin
               if (q.size() == 0) begin
                  check($sformatf("w%0d_extra", S), 1, 0);
               end else begin
                  e = q.pop_front();
                  check($sformatf("w%0d_res", S), {of, co, ws}, e);
                  got++;
               end
            end
         end
         check($sformatf("w%0d_drain", S), q.size(), 0);
         check($sformatf("w%0d_some", S), (got > 100), 1);
         fin = 1'b1;
      end
   end

   initial begin
      logic [33:0] q[$];
      logic [33:0] e;
      logic [17:0] prev;
      logic        held;
      int          idx, c, got, stalls, stale;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_outs", {ovf, cout, sum}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", in_ready, 1);
      tick();

      run_op("add12", 16'd12, 16'd120, 1'b1, 1'b0, 16'd133, 1'b0, 1'b0);
      run_op("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("sub5_7", 16'd5, 16'd7, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_op("sub_cin", 16'd5, 16'd7, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

      idx = 0; c = 0; got = 0; stalls = 0; held = 1'b0; prev = '0;
      while (got < 8 && c < 60) begin
         out_ready = !(c >= 5 && c < 8);
         in_valid  = (idx < 8);
         a = 16'(idx); b = 16'(100 * idx); cin = 1'b0; sub = 1'b0;
         #1;
         check("st_ready", in_ready, !(out_valid && !out_ready));
         if (!in_ready) stalls++;
         if (held) check("st_hold", {ovf, cout, sum}, prev);
         held = out_valid && !out_ready;
         prev = {ovf, cout, sum};
         if (in_valid && in_ready) begin
            q.push_back(ref_model(16, 32'(idx), 32'(100 * idx), 1'b0, 1'b0));
            idx++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("st_extra", 1, 0);
            end else begin
               e = q.pop_front();
               check("st_res", {ovf, cout, sum}, {e[33:32], e[15:0]});
            end
            got++;
         end
         @(posedge clk);
         #1;
         c++;
      end
      in_valid = 1'b0;
      check("st_count", got, 8);
      check("st_stalls", stalls, 3);
      check("st_left", q.size(), 0);

      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = 16'(i + 1); b = 16'd1; in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_outs", {ovf, cout, sum}, 0);
      check("mid_rst_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("mid_rel_ready", in_ready, 1);
      stale = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid) stale++;
      end
      check("mid_stale", stale, 0);
      run_op("post_rst", 16'h1234, 16'h0101, 1'b0, 1'b0, 16'h1335, 1'b0, 1'b0);

      phase = 1;
      wait (g_wide[0].fin);
      phase = 2;
      wait (g_wide[1].fin);
      phase = 3;
      wait (g_wide[2].fin);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipe_n_bit_adder.md
# pipe_n_bit_adder

Parametrised, pipelined successor to the combinational N-bit ripple adder. It splits a WIDTH-bit add or subtract into STAGES equal chunks and registers the carry between chunks, so a wide adder closes timing at clock rate. It accepts one operation per cycle over a valid/ready handshake and sits between an operand source and a result consumer that may apply backpressure.

## Interface
- WIDTH, 16: operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4: number of pipeline stages; each stage adds WIDTH/STAGES bits (CW). The range is 1..WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: a+b+cin; 1: a−b (a+~b+1), cin ignored.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. In subtract mode, 1 means no borrow (a ≥ b unsigned).
- ovf  out  1  signed overflow: both effective operands have the same MSB and the sum MSB differs from it.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Effective B is b^{WIDTH{sub}}. Effective carry-in is sub ? 1 : cin. Both are computed combinationally at input.
- Stage k (0..STAGES−1) adds chunk k of A and effective B, plus the carry registered from stage k−1 (stage 0 uses the effective carry-in). It registers:
  - the chunk-k sum,
  - the carry,
  - the sum chunks already completed by earlier stages,
  - the operand chunks not yet added (skew registers),
  - a per-stage valid bit.
- The last stage drives sum, cout and ovf from registers. ovf uses the MSB of A and effective B carried through the skew registers.
- Global advance enable is adv = !out_valid || out_ready. All stage registers load only when adv=1; when adv=0, every stage holds.
- in_ready = adv, combinational from out_valid and out_ready. in_ready never depends on in_valid.
- Bubbles are not collapsed. An empty stage still takes one advance to move.
- Results leave in acceptance order. No beat is dropped or duplicated.

## Timing
- Latency is exactly STAGES cycles from the input transfer edge to out_valid=1, when there is no stall.
- Throughput is 1 result per cycle while out_ready stays high.
- With out_valid=1 and out_ready=0, sum, cout and ovf stay stable until the transfer.
- Simultaneous in and out transfer in the same cycle is legal. The pipe stays full at steady state.
- Reset (asserted at any time, including mid-stream):
  - all valid bits clear immediately, so out_valid=0;
  - sum, cout and ovf read 0;
  - in-flight operations are discarded;
  - in_ready reads 1 while in reset and on the first edge after release.
- STAGES=1 degenerates to one registered full-width adder with latency 1.
- Boundary: a carry generated in stage 0 must propagate correctly through every later stage. Example: 0xFFFF+0x0001.

## Structure
- Shared package pipe_adder_pkg holds:
  - default WIDTH/STAGES constants,
  - CW = WIDTH/STAGES,
  - an elaboration check that WIDTH % STAGES == 0 (fail at elaboration otherwise).
- Sub-module adder_chunk is one CW-bit add with carry in and carry out, plus its output registers with enable. The top instantiates STAGES copies in a generate loop and adds the skew and valid registers.
- The existing combinational N-bit adder is not reused inside; each chunk is self-contained.

## Test plan
- WIDTH=16, STAGES=4. Drive a=12, b=120, cin=1, sub=0 with out_ready=1. Expect sum=133, cout=0, ovf=0, with out_valid high exactly 4 cycles after acceptance.
- a=0xFFFF, b=0x0001, cin=0. Expect sum=0x0000, cout=1, ovf=0; the carry crosses all 4 chunks. Then a=0x7FFF, b=0x0001 gives sum=0x8000, cout=0, ovf=1.
- sub=1 cases:
  - a=5, b=7 gives sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001 gives sum=0x7FFF, cout=1, ovf=1.
  - cin=1 has no effect.
- Stream 8 back-to-back ops (a=i, b=100·i) with out_ready low for 3 cycles mid-stream. Expect:
  - in_ready low exactly during the stall while out_valid=1;
  - outputs held stable during the stall;
  - 8 results in order, no loss or duplicate.
- Assert rst_n low for 1 cycle with 3 ops in flight. Expect out_valid=0 immediately, no stale results after release, and the next op's result is correct at latency 4.
- Repeat the randomized checks against a+b+cin / a−b reference models for WIDTH=32 with STAGES=1, 2 and 8.
